findmax_axis_stall_detector: RTL and testbench
==============================================

Name: findmax_axis_stall_detector

Overview:
Upstream feeder of the findmax deadlock monitor. Passively taps the two AXI-Stream channels of the findmax instance (input stream, output stream) and produces the 2-bit per-channel blocking vector that the monitor consumes as axis_block_sigs. Adds persistence filtering (a stall must hold STALL_THRESH consecutive cycles before it is reported), saturating per-channel stall-cycle statistics and sticky flags for debug readout.

Parameters:
STALL_THRESH, 4, consecutive wait cycles before a channel is reported blocked; legal range >= 1
CNT_W, 32, width of each saturating stall-cycle statistic counter

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (assert async, deassert sync to clock externally)
in_tvalid  in  1  input-stream TVALID (tap, upstream producer to findmax)
in_tready  in  1  input-stream TREADY (tap, findmax requesting data)
out_tvalid  in  1  output-stream TVALID (tap, findmax producing)
out_tready  in  1  output-stream TREADY (tap, downstream consumer)
inst_idle  in  1  findmax ap_idle; suppresses input-channel wait detection
clear_stats  in  1  single-cycle pulse: clear stall counters and sticky flags
axis_block_sigs  out  2  [0]=input channel blocked, [1]=output channel blocked; to deadlock monitor
stall_cycles0  out  CNT_W  total input-channel wait cycles, saturating
stall_cycles1  out  CNT_W  total output-channel wait cycles, saturating
sticky_block  out  2  per-channel latch: set once channel was ever reported blocked

Behaviour:
- Taps only; never drives TVALID/TREADY.
- Wait condition, evaluated every cycle:
  - ch0: in_tready & ~in_tvalid & ~inst_idle
  - ch1: out_tvalid & ~out_tready
- A handshake cycle (tvalid & tready) is never a wait cycle.
- Per-channel FSM, states IDLE, WAIT, BLOCKED; run counter width clog2(STALL_THRESH+1).
  - IDLE: wait -> run=1; to BLOCKED if STALL_THRESH==1, else to WAIT.
  - WAIT: wait -> run+1; to BLOCKED when run+1 == STALL_THRESH. No wait -> IDLE, run=0.
  - BLOCKED: stay while wait, run held. No wait -> IDLE, run=0.
- axis_block_sigs[i] = (state==BLOCKED), registered. It rises the cycle after the STALL_THRESH-th consecutive wait cycle and falls the cycle after the first non-wait cycle.
- stall_cycles[i]:
  - +1 on every wait cycle in any state; saturates at all-ones, no wrap.
  - clear_stats in the same cycle as a wait: clear wins, result 0.
- sticky_block[i]:
  - Sets on the cycle axis_block_sigs[i] rises (same edge).
  - clear_stats clears it; simultaneous set and clear: set wins.
- inst_idle affects only ch0. With inst_idle high, a ch0 stall breaks (FSM -> IDLE next cycle). ch1 is unaffected, because a pending output beat still blocks.
- Channels are fully independent; both may be BLOCKED at once.
- Reset (async, low): all FSMs IDLE, run counters 0, axis_block_sigs=2'b00, stall_cycles0/1=0, sticky_block=2'b00. Reset mid-stall discards all history; counting restarts from 0 after release.
- Latency: none beyond the single register stage described above; no combinational input-to-output paths.

Decomposition:
- Package findmax_mon_pkg: channel index constants CH_IN=0 and CH_OUT=1; channel FSM state enum (IDLE, WAIT, BLOCKED); default STALL_THRESH.
- Sub-module findmax_axis_chan_stall: one channel's FSM, run counter, saturating stat counter and sticky flag. Inputs are the wait condition and clear_stats. Instantiated twice; the top level forms the wait conditions and concatenates the outputs.

Test Plan:
- STALL_THRESH=4; ch1 out_tvalid=1, out_tready=0 for 3 cycles, then out_tready=1 -> axis_block_sigs stays 2'b00; stall_cycles1=3; sticky_block=0.
- Same stall held 6 cycles -> axis_block_sigs[1] rises the cycle after wait cycle 4, stays high 3 cycles, falls the cycle after the handshake; stall_cycles1=6; sticky_block[1]=1.
- ch0 in_tready=1, in_tvalid=0 for 10 cycles with inst_idle=1 -> axis_block_sigs[0]=0 and stall_cycles0=0. Repeat with inst_idle=0 -> block at cycle 5, stall_cycles0=10.
- CNT_W=4; continuous ch1 wait for 20 cycles -> stall_cycles1 saturates at 15, no wrap. clear_stats pulse during the wait -> reads 0 next cycle, then increments; sticky_block[1] re-sets if the FSM is still BLOCKED.
- Both channels stalled 5 cycles; reset pulled low mid-stall, then released -> all outputs 0 immediately on assertion; after release, re-block requires 4 fresh wait cycles.
- STALL_THRESH=1; single ch1 wait cycle -> axis_block_sigs[1] high for exactly one cycle, on the following cycle.

Source files
------------

// File: rtl/findmax_mon_pkg.sv
// Shared definitions for the findmax deadlock-monitor front end:
// channel indices, per-channel stall FSM states and the default threshold.
package findmax_mon_pkg;

   localparam int CH_IN            = 0;
   localparam int CH_OUT           = 1;
   localparam int DEF_STALL_THRESH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      BLOCKED = 2'd2
   } chan_state_e;

endpackage

// File: rtl/findmax_axis_chan_stall.sv
// One AXI-Stream channel's stall tracker: persistence-filtered blocked flag,
// saturating wait-cycle statistic and a sticky "was ever blocked" flag.
module findmax_axis_chan_stall
   import findmax_mon_pkg::*;
#(
   parameter int STALL_THRESH = DEF_STALL_THRESH,
   parameter int CNT_W        = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall_wait,
   input  logic             clear_stats,
   output logic             blocked,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             sticky
);

   localparam int               RUN_W      = $clog2(STALL_THRESH + 1);
   localparam logic [RUN_W-1:0] THRESH_RUN = RUN_W'(STALL_THRESH);
   localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

   chan_state_e      state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] stat_q, stat_d;
   logic             blocked_q, blocked_d;
   logic             sticky_q, sticky_d;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      run_d   = run_q;
      case (state_q)
         IDLE: begin
            if (stall_wait) begin
               run_d   = RUN_ONE;
               state_d = (STALL_THRESH == 1) ? BLOCKED : WAIT;
            end
         end
         WAIT: begin
            if (stall_wait) begin
               run_d = run_q + RUN_ONE;
               if (run_q + RUN_ONE == THRESH_RUN) begin
                  state_d = BLOCKED;
               end
            end else begin
               state_d = IDLE;
               run_d   = '0;
            end
         end
         BLOCKED: begin
            // Run length is held while blocked; it only matters again after a break.
            if (!stall_wait) begin
               state_d = IDLE;
               run_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            run_d   = '0;
         end
      endcase
   end

   always_comb begin
      stat_d = stat_q;
      if (clear_stats) begin
         stat_d = '0;
      end else if (stall_wait && (stat_q != '1)) begin
         stat_d = stat_q + CNT_W'(1);
      end
   end

   // Level-set on BLOCKED so a clear issued mid-block is immediately re-armed.
   assign blocked_d = (state_d == BLOCKED);
   assign sticky_d  = blocked_d | (sticky_q & ~clear_stats);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         run_q     <= '0;
         stat_q    <= '0;
         blocked_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
         state_q   <= state_d;
         run_q     <= run_d;
         stat_q    <= stat_d;
         blocked_q <= blocked_d;
         sticky_q  <= sticky_d;
      end
   end

   assign blocked      = blocked_q;
   assign stall_cycles = stat_q;
   assign sticky       = sticky_q;

endmodule

// File: rtl/findmax_axis_stall_detector.sv
// Passive tap on findmax's input and output AXI-Stream channels; produces the
// per-channel blocking vector for the deadlock monitor plus debug statistics.
module findmax_axis_stall_detector
   import findmax_mon_pkg::*;
#(
   parameter int STALL_THRESH = DEF_STALL_THRESH,
   parameter int CNT_W        = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_tvalid,
   input  logic             in_tready,
   input  logic             out_tvalid,
   input  logic             out_tready,
   input  logic             inst_idle,
   input  logic             clear_stats,
   output logic [1:0]       axis_block_sigs,
   output logic [CNT_W-1:0] stall_cycles0,
   output logic [CNT_W-1:0] stall_cycles1,
   output logic [1:0]       sticky_block
);

   logic wait_in;
   logic wait_out;

   // An idle instance is not starved, so only a running findmax waiting on input counts.
   assign wait_in  = in_tready & ~in_tvalid & ~inst_idle;
   assign wait_out = out_tvalid & ~out_tready;

   findmax_axis_chan_stall #(
      .STALL_THRESH (STALL_THRESH),
      .CNT_W        (CNT_W)
   ) u_ch_in (
      .clock        (clock),
      .reset        (reset),
      .stall_wait   (wait_in),
      .clear_stats  (clear_stats),
      .blocked      (axis_block_sigs[CH_IN]),
      .stall_cycles (stall_cycles0),
      .sticky       (sticky_block[CH_IN])
   );

   findmax_axis_chan_stall #(
      .STALL_THRESH (STALL_THRESH),
      .CNT_W        (CNT_W)
   ) u_ch_out (
      .clock        (clock),
      .reset        (reset),
      .stall_wait   (wait_out),
      .clear_stats  (clear_stats),
      .blocked      (axis_block_sigs[CH_OUT]),
      .stall_cycles (stall_cycles1),
      .sticky       (sticky_block[CH_OUT])
   );

endmodule

// File: tb/tb_findmax_axis_stall_detector.sv
// Bench for findmax_axis_stall_detector: three parameterisations driven by shared
// stimulus, compared each cycle against a run-length reference model.
module tb_findmax_axis_stall_detector;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic in_tvalid = 1'b0, in_tready = 1'b0;
   logic out_tvalid = 1'b0, out_tready = 1'b0;
   logic inst_idle = 1'b0, clear_stats = 1'b0;

   always #5 clock = ~clock;

   // d=0: TH=4/CNT_W=32, d=1: TH=4/CNT_W=4, d=2: TH=1/CNT_W=32
   logic [1:0]  blk_o [3];
   logic [1:0]  stk_o [3];
   logic [31:0] s0_o  [3];
   logic [31:0] s1_o  [3];
   logic [31:0] a_s0, a_s1, c_s0, c_s1;
   logic [3:0]  b_s0, b_s1;

   findmax_axis_stall_detector #(.STALL_THRESH(4), .CNT_W(32)) u_a (
      .clock(clock), .reset(reset), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .inst_idle(inst_idle),
      .clear_stats(clear_stats), .axis_block_sigs(blk_o[0]), .stall_cycles0(a_s0),
      .stall_cycles1(a_s1), .sticky_block(stk_o[0]));

   findmax_axis_stall_detector #(.STALL_THRESH(4), .CNT_W(4)) u_b (
      .clock(clock), .reset(reset), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .inst_idle(inst_idle),
      .clear_stats(clear_stats), .axis_block_sigs(blk_o[1]), .stall_cycles0(b_s0),
      .stall_cycles1(b_s1), .sticky_block(stk_o[1]));

   findmax_axis_stall_detector #(.STALL_THRESH(1), .CNT_W(32)) u_c (
      .clock(clock), .reset(reset), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .out_tvalid(out_tvalid), .out_tready(out_tready), .inst_idle(inst_idle),
      .clear_stats(clear_stats), .axis_block_sigs(blk_o[2]), .stall_cycles0(c_s0),
      .stall_cycles1(c_s1), .sticky_block(stk_o[2]));

   assign s0_o[0] = a_s0;
   assign s1_o[0] = a_s1;
   assign s0_o[1] = {28'b0, b_s0};
   assign s1_o[1] = {28'b0, b_s1};
   assign s0_o[2] = c_s0;
   assign s1_o[2] = c_s1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: length of the current unbroken wait run per channel.
   int     th  [3] = '{4, 4, 1};
   longint mx  [3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
   longint run [3][2];
   longint stat[3][2];
   bit     mblk[3][2];
   bit     mstk[3][2];

   task automatic model_reset();
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 2; c++) begin
            run[d][c] = 0; stat[d][c] = 0; mblk[d][c] = 0; mstk[d][c] = 0;
         end
   endtask

   task automatic model_step();
      bit w[2];
      w[0] = in_tready && !in_tvalid && !inst_idle;
      w[1] = out_tvalid && !out_tready;
      if (!reset) begin
         model_reset();
         return;
      end
      for (int d = 0; d < 3; d++)
         for (int c = 0; c < 2; c++) begin
            run[d][c]  = w[c] ? run[d][c] + 1 : 0;
            mblk[d][c] = (run[d][c] >= th[d]);
            if (clear_stats)                    stat[d][c] = 0;
            else if (w[c] && stat[d][c] < mx[d]) stat[d][c]++;
            mstk[d][c] = mblk[d][c] || (mstk[d][c] && !clear_stats);
         end
   endtask

   task automatic compare_all();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("u%0d_block", d),  32'(blk_o[d]), 32'({mblk[d][1], mblk[d][0]}));
         check($sformatf("u%0d_sticky", d), 32'(stk_o[d]), 32'({mstk[d][1], mstk[d][0]}));
         check($sformatf("u%0d_stall0", d), s0_o[d], 32'(stat[d][0]));
         check($sformatf("u%0d_stall1", d), s1_o[d], 32'(stat[d][1]));
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      in_tvalid = 0; in_tready = 0; out_tvalid = 0; out_tready = 0;
      inst_idle = 0; clear_stats = 0;
   endtask

   task automatic clear_pulse();
      clear_stats = 1;
      cyc();
      clear_stats = 0;
   endtask

   initial begin
      model_reset();
      idle_inputs();
      #12;
      check("reset_block", 32'(blk_o[0]), 32'd0);
      check("reset_stall1", s1_o[0], 32'd0);
      cyc();
      reset = 1;
      cyc();
      check("post_reset_sticky", 32'(stk_o[0]), 32'd0);

      // Short output stall (3 cycles) then handshake: never reported.
      clear_pulse();
      out_tvalid = 1; out_tready = 0;
      repeat (3) begin
         cyc();
         check("short_no_block", 32'(blk_o[0]), 32'd0);
      end
      out_tready = 1; cyc();
      out_tvalid = 0; out_tready = 0; cyc();
      check("short_stall1", s1_o[0], 32'd3);
      check("short_sticky", 32'(stk_o[0]), 32'd0);

      // Six-cycle output stall: blocked visible after wait 4, for 3 cycles.
      clear_pulse();
      out_tvalid = 1; out_tready = 0;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         check($sformatf("long_block_%0d", i), 32'(blk_o[0][1]), (i >= 4) ? 32'd1 : 32'd0);
      end
      out_tready = 1; cyc();
      check("long_fall", 32'(blk_o[0][1]), 32'd0);
      out_tvalid = 0; out_tready = 0; cyc();
      check("long_stall1", s1_o[0], 32'd6);
      check("long_sticky1", 32'(stk_o[0][1]), 32'd1);

      // Input starvation while idle is ignored; while running it blocks.
      clear_pulse();
      in_tready = 1; in_tvalid = 0; inst_idle = 1;
      repeat (10) cyc();
      check("idle_block0", 32'(blk_o[0][0]), 32'd0);
      check("idle_stall0", s0_o[0], 32'd0);
      inst_idle = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         check($sformatf("run_block0_%0d", i), 32'(blk_o[0][0]), (i >= 4) ? 32'd1 : 32'd0);
      end
      check("run_stall0", s0_o[0], 32'd10);
      inst_idle = 1; cyc();
      check("idle_breaks_block0", 32'(blk_o[0][0]), 32'd0);
      idle_inputs(); cyc();

      // Saturation on the 4-bit counter and clear during an ongoing block.
      clear_pulse();
      out_tvalid = 1; out_tready = 0;
      repeat (20) cyc();
      check("sat_stall1", s1_o[1], 32'd15);
      clear_stats = 1; cyc(); clear_stats = 0;
      check("clr_wins", s1_o[1], 32'd0);
      check("clr_sticky_reset", 32'(stk_o[1][1]), 32'd1);
      cyc();
      check("clr_then_inc", s1_o[1], 32'd1);
      idle_inputs(); cyc();

      // Both channels stalled, reset mid-stall.
      clear_pulse();
      in_tready = 1; in_tvalid = 0; out_tvalid = 1; out_tready = 0;
      repeat (5) cyc();
      check("both_blocked", 32'(blk_o[0]), 32'd3);
      #2 reset = 0;
      #1;
      model_reset();
      compare_all();
      check("rst_async_block", 32'(blk_o[0]), 32'd0);
      check("rst_async_stall0", s0_o[0], 32'd0);
      repeat (2) cyc();
      reset = 1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check($sformatf("reblock_%0d", i), 32'(blk_o[0]), (i == 4) ? 32'd3 : 32'd0);
      end
      idle_inputs(); cyc();

      // Threshold 1: a single wait cycle gives a one-cycle block pulse.
      clear_pulse();
      out_tvalid = 1; out_tready = 0; cyc();
      check("th1_rise", 32'(blk_o[2][1]), 32'd1);
      out_tvalid = 0; cyc();
      check("th1_fall", 32'(blk_o[2][1]), 32'd0);
      check("th1_sticky", 32'(stk_o[2][1]), 32'd1);

      // Random phase with persistent (slowly toggling) handshake signals.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) in_tvalid  = ~in_tvalid;
         if ($urandom_range(0, 7) == 0) in_tready  = ~in_tready;
         if ($urandom_range(0, 7) == 0) out_tvalid = ~out_tvalid;
         if ($urandom_range(0, 7) == 0) out_tready = ~out_tready;
         if ($urandom_range(0, 15) == 0) inst_idle = ~inst_idle;
         clear_stats = ($urandom_range(0, 39) == 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
